// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad reader with column scan and debounce.
// Ports: clk, reset (async high), row[3:0] (active-low pins),
//        col[3:0] (active-low drive), key_code[3:0], key_valid, key_held.
module keypad_scanner #(
    parameter int SCAN_DIV     = 16,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int MW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DW-1:0] DLAST = DW'(SCAN_DIV - 1);
    localparam logic [MW-1:0] MLAST = MW'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED
    } state_t;

    state_t        state;
    logic [3:0]    r1;
    logic [3:0]    rs;
    logic [DW-1:0] dwell;
    logic [MW-1:0] mcnt;
    logic [1:0]    col_idx;
    logic [1:0]    row_idx;
    logic [1:0]    low_idx;
    logic          sample;

    assign sample = (dwell == DLAST);

    // Lowest-numbered active row wins when several are low.
    always_comb begin
        low_idx = 2'd3;
        if (!rs[0])
            low_idx = 2'd0;
        else if (!rs[1])
            low_idx = 2'd1;
        else if (!rs[2])
            low_idx = 2'd2;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r1 <= 4'hF;
            rs <= 4'hF;
        end else begin
            r1 <= row;
            rs <= r1;
        end
    end

    // Free-running dwell timer; never restarted by state changes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            dwell <= '0;
        else if (sample)
            dwell <= '0;
        else
            dwell <= dwell + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SCAN;
            col       <= 4'b1110;
            col_idx   <= 2'd0;
            row_idx   <= 2'd0;
            mcnt      <= '0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (sample) begin
                case (state)
                    SCAN: begin
                        if (rs == 4'hF) begin
                            col_idx <= col_idx + 2'd1;
                            col     <= {col[2:0], col[3]};
                        end else begin
                            row_idx <= low_idx;
                            if (DEBOUNCE_CNT == 1) begin
                                key_code  <= {low_idx, col_idx};
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                mcnt      <= '0;
                                state     <= PRESSED;
                            end else begin
                                mcnt  <= MW'(1);
                                state <= DEBOUNCE;
                            end
                        end
                    end
                    DEBOUNCE: begin
                        if (!rs[row_idx]) begin
                            if (mcnt == MLAST) begin
                                key_code  <= {row_idx, col_idx};
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                mcnt      <= '0;
                                state     <= PRESSED;
                            end else begin
                                mcnt <= mcnt + 1'b1;
                            end
                        end else begin
                            // Bounce: drop the candidate, move on.
                            mcnt    <= '0;
                            col_idx <= col_idx + 2'd1;
                            col     <= {col[2:0], col[3]};
                            state   <= SCAN;
                        end
                    end
                    PRESSED: begin
                        if (rs[row_idx]) begin
                            if (mcnt == MLAST) begin
                                key_held <= 1'b0;
                                mcnt     <= '0;
                                col_idx  <= col_idx + 2'd1;
                                col      <= {col[2:0], col[3]};
                                state    <= SCAN;
                            end else begin
                                mcnt <= mcnt + 1'b1;
                            end
                        end else begin
                            mcnt <= '0;
                        end
                    end
                    default: begin
                        state <= SCAN;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed table-driven bench for keypad_scanner.
// Models the key matrix and checks each sample period.
module tb_keypad_scanner;

    logic       clk;
    logic       reset;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic [15:0] keys;

    int total;
    int bad;

    keypad_scanner #(
        .SCAN_DIV    (4),
        .DEBOUNCE_CNT(3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .row      (row),
        .col      (col),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical matrix: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col[c])
                    row[r] = 1'b0;
    end

    typedef struct {
        logic [15:0] keys;
        logic [3:0]  col;
        int          pulses;
        logic        held;
        logic [3:0]  code;
    } vec_t;

    vec_t tv[36];

    localparam logic [15:0] K9  = 16'h0200;
    localparam logic [15:0] K1  = 16'h0002;
    localparam logic [15:0] K2  = 16'h0004;
    localparam logic [15:0] K14 = 16'h4000;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic setv(input int i, input logic [15:0] k, input logic [3:0] c,
                        input int p, input logic h, input logic [3:0] kc);
        tv[i].keys   = k;
        tv[i].col    = c;
        tv[i].pulses = p;
        tv[i].held   = h;
        tv[i].code   = kc;
    endtask

    // Drive keys, advance to just after the next sample edge, compare.
    task automatic run_vec(input int i);
        int p;
        keys = tv[i].keys;
        p = 0;
        for (int e = 0; e < 4; e++) begin
            @(posedge clk);
            #1;
            if (key_valid)
                p++;
        end
        chk($sformatf("v%0d col", i), int'(col), int'(tv[i].col));
        chk($sformatf("v%0d pulses", i), p, tv[i].pulses);
        chk($sformatf("v%0d valid_at_sample", i), int'(key_valid),
            (tv[i].pulses > 0) ? 1 : 0);
        chk($sformatf("v%0d held", i), int'(key_held), int'(tv[i].held));
        chk($sformatf("v%0d code", i), int'(key_code), int'(tv[i].code));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        keys  = 16'h0;

        // Idle scan
        setv(0,  16'h0, 4'b1101, 0, 0, 4'h0);
        setv(1,  16'h0, 4'b1011, 0, 0, 4'h0);
        setv(2,  16'h0, 4'b0111, 0, 0, 4'h0);
        setv(3,  16'h0, 4'b1110, 0, 0, 4'h0);
        setv(4,  16'h0, 4'b1101, 0, 0, 4'h0);
        // Key 9 press, accepted on third match
        setv(5,  K9,    4'b1101, 0, 0, 4'h0);
        setv(6,  K9,    4'b1101, 0, 0, 4'h0);
        setv(7,  K9,    4'b1101, 1, 1, 4'h9);
        setv(8,  K9,    4'b1101, 0, 1, 4'h9);
        // Release with one re-bounce
        setv(9,  16'h0, 4'b1101, 0, 1, 4'h9);
        setv(10, 16'h0, 4'b1101, 0, 1, 4'h9);
        setv(11, K9,    4'b1101, 0, 1, 4'h9);
        setv(12, 16'h0, 4'b1101, 0, 1, 4'h9);
        setv(13, 16'h0, 4'b1101, 0, 1, 4'h9);
        setv(14, 16'h0, 4'b1011, 0, 0, 4'h9);
        setv(15, 16'h0, 4'b0111, 0, 0, 4'h9);
        setv(16, 16'h0, 4'b1110, 0, 0, 4'h9);
        setv(17, 16'h0, 4'b1101, 0, 0, 4'h9);
        // Single-sample bounce is abandoned
        setv(18, K9,    4'b1101, 0, 0, 4'h9);
        setv(19, 16'h0, 4'b1011, 0, 0, 4'h9);
        // Rows 0 and 3 in column 2: row 0 wins
        setv(20, K2|K14, 4'b1011, 0, 0, 4'h9);
        setv(21, K2|K14, 4'b1011, 0, 0, 4'h9);
        setv(22, K2|K14, 4'b1011, 1, 1, 4'h2);
        setv(23, 16'h0, 4'b1011, 0, 1, 4'h2);
        setv(24, 16'h0, 4'b1011, 0, 1, 4'h2);
        setv(25, 16'h0, 4'b0111, 0, 0, 4'h2);
        setv(26, 16'h0, 4'b1110, 0, 0, 4'h2);
        setv(27, 16'h0, 4'b1101, 0, 0, 4'h2);
        // Re-press key 9, second key in same column ignored
        setv(28, K9,    4'b1101, 0, 0, 4'h2);
        setv(29, K9,    4'b1101, 0, 0, 4'h2);
        setv(30, K9,    4'b1101, 1, 1, 4'h9);
        setv(31, K9|K1, 4'b1101, 0, 1, 4'h9);
        // After mid-PRESSED reset, key still down: fresh debounce needed
        setv(32, K9,    4'b1101, 0, 0, 4'h0);
        setv(33, K9,    4'b1101, 0, 0, 4'h0);
        setv(34, K9,    4'b1101, 0, 0, 4'h0);
        setv(35, K9,    4'b1101, 1, 1, 4'h9);

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst col", int'(col), 4'b1110);
        chk("rst valid", int'(key_valid), 0);
        chk("rst held", int'(key_held), 0);
        chk("rst code", int'(key_code), 0);
        reset = 1'b0;

        for (int i = 0; i < 32; i++)
            run_vec(i);

        // Asynchronous reset while PRESSED, away from any clock edge
        #2;
        reset = 1'b1;
        #1;
        chk("mid rst col", int'(col), 4'b1110);
        chk("mid rst valid", int'(key_valid), 0);
        chk("mid rst held", int'(key_held), 0);
        chk("mid rst code", int'(key_code), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 32; i < 36; i++)
            run_vec(i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
